fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the pipelined CPU's decode stage.
- Generates sequential fetch addresses, issues them to instruction memory, and buffers returned instructions with their PCs in a small FIFO.
- Hands instructions to decode under a valid/ready handshake.
- Accepts branch redirects from the execute stage: on a redirect it flushes buffered and in-flight instructions and restarts fetch at the target.

---
 rtl/fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with in-order response buffering,
// a valid/ready decode handshake and flush-on-redirect.
// Ports: clk/rst (sync, active-high); imem_req/imem_addr, imem_rsp_valid/inst;
//        redirect/redirect_pc; halt; dec_valid/dec_ready/dec_inst/dec_pc; empty.
// Optional macro FETCH_STATS_EN adds stat_flushes, stat_dropped, stat_stall.
module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              empty
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_flushes,
  output logic [31:0]       stat_dropped,
  output logic [31:0]       stat_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {BOOT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [PW-1:0]     qwr_q, qwr_d;
  logic [PW-1:0]     qrd_q, qrd_d;
  logic [PW-1:0]     fwr_q, fwr_d;
  logic [PW-1:0]     frd_q, frd_d;

  logic [ADDR_W-1:0] ent_pc_q   [DEPTH];
  logic [INST_W-1:0] ent_inst_q [DEPTH];
  logic [ADDR_W-1:0] fl_pc_q    [DEPTH];

  logic rsp_ok, credit, issue, pop, push;
  logic unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // Responses with nothing outstanding are ignored entirely.
  assign rsp_ok = imem_rsp_valid && (out_q != '0);
  // Occupancy plus outstanding never exceeds DEPTH, so every
  // returning response is guaranteed a queue slot.
  assign credit = ({1'b0, occ_q} + {1'b0, out_q})
                < (CW+1)'(DEPTH);
  assign issue  = (state_q == RUN) && !halt
               && !redirect && credit;
  assign dec_valid = (occ_q != '0);
  assign pop    = dec_valid && dec_ready && !redirect;
  assign push   = rsp_ok && (drop_q == '0) && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign empty     = (occ_q == '0);
  assign dec_inst  = dec_valid ? ent_inst_q[qrd_q] : '0;
  assign dec_pc    = dec_valid ? ent_pc_q[qrd_q] : '0;

  always_comb begin
    state_d    = RUN;
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q + CW'(push) - CW'(pop);
    qwr_d      = qwr_q + PW'(push);
    qrd_d      = qrd_q + PW'(pop);
    out_d      = out_q + CW'(issue) - CW'(rsp_ok);
    fwr_d      = fwr_q + PW'(issue);
    frd_d      = frd_q + PW'(rsp_ok);
    drop_d     = drop_q
               - CW'(rsp_ok && (drop_q != '0));
    unique case (1'b1)
      redirect: fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      issue:    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      default:  fetch_pc_d = fetch_pc_q;
    endcase
    if (redirect) begin
      occ_d  = '0;
      qwr_d  = '0;
      qrd_d  = '0;
      // Everything still pending after this cycle is stale.
      drop_d = out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      qwr_q      <= '0;
      qrd_q      <= '0;
      fwr_q      <= '0;
      frd_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      qwr_q      <= qwr_d;
      qrd_q      <= qrd_d;
      fwr_q      <= fwr_d;
      frd_q      <= frd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) fl_pc_q[fwr_q] <= fetch_pc_q;
    if (push) begin
      ent_pc_q[qwr_q]   <= fl_pc_q[frd_q];
      ent_inst_q[qwr_q] <= imem_rsp_inst;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        dropped, stalled;

  assign dropped = rsp_ok && ((drop_q != '0) || redirect);
  assign stalled = (state_q == RUN) && dec_ready && !dec_valid;

  always_comb begin
    flush_cnt_d = flush_cnt_q
                + 32'(redirect && (flush_cnt_q != '1));
    drop_cnt_d  = drop_cnt_q
                + 32'(dropped && (drop_cnt_q != '1));
    stall_cnt_d = stall_cnt_q
                + 32'(stalled && (stall_cnt_q != '1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_flushes = flush_cnt_q;
  assign stat_dropped = drop_cnt_q;
  assign stat_stall   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios for fetch_queue with a
// fixed-latency in-order instruction memory model.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [63:0] dec_pc;
  logic        empty;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_flushes, stat_dropped, stat_stall;
`endif

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_inst(imem_rsp_inst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst), .dec_pc(dec_pc),
    .empty(empty)
`ifdef FETCH_STATS_EN
    , .stat_flushes(stat_flushes)
    , .stat_dropped(stat_dropped)
    , .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int req_cnt = 0;
  logic        req_seen;
  logic [63:0] addr_seen;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_inst[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
  endfunction

  // One clock: memory drives its response, requests and pops that
  // will happen at the coming edge are logged, then advance to negedge.
  task automatic cycle();
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_inst  = '0;
    end
    #1;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    if (imem_req && !rst) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      req_cnt++;
    end
    if (dec_valid && dec_ready && !redirect && !rst) begin
      pop_pc.push_back(dec_pc);
      pop_inst.push_back(dec_inst);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    halt = 1'b0; dec_ready = 1'b0;
    pend_addr.delete(); pend_due.delete();
    run(2);
    rst = 1'b0;
    pop_pc.delete(); pop_inst.delete();
    req_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    dec_ready = 1'b1;
    run(1);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", dec_valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", empty); end
    total++; if (dec_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", dec_inst); end
    total++; if (dec_pc !== 64'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", dec_pc); end
    rst = 1'b0;
    cycle();
    total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL boot_req got=%b want=0", req_seen); end
    cycle();
    total++; if (req_seen !== 1'b1) begin bad++; $display("FAIL first_req got=%b want=1", req_seen); end
    total++; if (addr_seen !== 64'h0) begin bad++; $display("FAIL first_addr got=%h want=0", addr_seen); end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; dec_ready = 1'b1;
    cycle();
    run(20);
    total++; if (pop_pc.size() != 18) begin bad++; $display("FAIL stream_count got=%0d want=18", pop_pc.size()); end
    for (int i = 0; i < 18 && i < pop_pc.size(); i++) begin
      total++; if (pop_pc[i] !== 64'(4*i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, pop_pc[i], 64'(4*i)); end
      total++; if (pop_inst[i] !== mem_word(64'(4*i))) begin bad++; $display("FAIL stream_inst[%0d] got=%h want=%h", i, pop_inst[i], mem_word(64'(4*i))); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; dec_ready = 1'b0;
    cycle();
    run(20);
    total++; if (req_cnt != 4) begin bad++; $display("FAIL bp_reqs got=%0d want=4", req_cnt); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b want=0", imem_req); end
    total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", dec_valid); end
    total++; if (dec_pc !== 64'h0) begin bad++; $display("FAIL bp_head got=%h want=0", dec_pc); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", empty); end
    dec_ready = 1'b1;
    cycle();
    total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL bp_rel0 got=%b want=0", req_seen); end
    cycle();
    total++; if (req_seen !== 1'b1 || addr_seen !== 64'h10) begin bad++; $display("FAIL bp_resume got=%b/%h want=1/10", req_seen, addr_seen); end
    run(8);
    total++; if (pop_pc.size() < 6) begin bad++; $display("FAIL bp_count got=%0d want>=6", pop_pc.size()); end
    for (int i = 0; i < 6 && i < pop_pc.size(); i++) begin
      total++; if (pop_pc[i] !== 64'(4*i)) begin bad++; $display("FAIL bp_pc[%0d] got=%h want=%h", i, pop_pc[i], 64'(4*i)); end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat = 3; dec_ready = 1'b0;
    cycle();
    run(3);
    halt = 1'b1;
    cycle();
    total++; if (dec_valid !== 1'b1 || dec_pc !== 64'h0) begin bad++; $display("FAIL rif_pre got=%b/%h want=1/0", dec_valid, dec_pc); end
    redirect = 1'b1; redirect_pc = 64'h100; halt = 1'b0;
    cycle();
    total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL rif_noreq got=%b want=0", req_seen); end
    redirect = 1'b0;
    total++; if (empty !== 1'b1 || dec_valid !== 1'b0) begin bad++; $display("FAIL rif_flush got=%b/%b want=1/0", empty, dec_valid); end
    cycle();
    total++; if (req_seen !== 1'b1 || addr_seen !== 64'h100) begin bad++; $display("FAIL rif_restart got=%b/%h want=1/100", req_seen, addr_seen); end
    dec_ready = 1'b1;
    run(8);
    total++; if (pop_pc.size() < 2) begin bad++; $display("FAIL rif_count got=%0d want>=2", pop_pc.size()); end
    if (pop_pc.size() >= 2) begin
      total++; if (pop_pc[0] !== 64'h100) begin bad++; $display("FAIL rif_pc0 got=%h want=100", pop_pc[0]); end
      total++; if (pop_inst[0] !== mem_word(64'h100)) begin bad++; $display("FAIL rif_inst0 got=%h want=%h", pop_inst[0], mem_word(64'h100)); end
      total++; if (pop_pc[1] !== 64'h104) begin bad++; $display("FAIL rif_pc1 got=%h want=104", pop_pc[1]); end
    end
    lat = 1;
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    lat = 1; dec_ready = 1'b1;
    cycle();
    run(2);
    total++; if (dec_valid !== 1'b1 || dec_pc !== 64'h0) begin bad++; $display("FAIL rr_pre got=%b/%h want=1/0", dec_valid, dec_pc); end
    redirect = 1'b1; redirect_pc = 64'h2003;
    cycle();
    total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL rr_noreq got=%b want=0", req_seen); end
    redirect = 1'b0;
    run(6);
    total++; if (pop_pc.size() < 1) begin bad++; $display("FAIL rr_count got=%0d want>=1", pop_pc.size()); end
    if (pop_pc.size() >= 1) begin
      total++; if (pop_pc[0] !== 64'h2000) begin bad++; $display("FAIL rr_pc0 got=%h want=2000", pop_pc[0]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1; dec_ready = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect = 1'b0;
    run(6);
    total++; if (pop_pc.size() < 3) begin bad++; $display("FAIL wrap_count got=%0d want>=3", pop_pc.size()); end
    if (pop_pc.size() >= 3) begin
      total++; if (pop_pc[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_pc0 got=%h want=fffffffffffffffc", pop_pc[0]); end
      total++; if (pop_inst[0] !== mem_word(64'hFFFF_FFFF_FFFF_FFFC)) begin bad++; $display("FAIL wrap_inst0 got=%h want=%h", pop_inst[0], mem_word(64'hFFFF_FFFF_FFFF_FFFC)); end
      total++; if (pop_pc[1] !== 64'h0) begin bad++; $display("FAIL wrap_pc1 got=%h want=0", pop_pc[1]); end
      total++; if (pop_pc[2] !== 64'h4) begin bad++; $display("FAIL wrap_pc2 got=%h want=4", pop_pc[2]); end
    end
  endtask

  task automatic test_boot_redirect();
    do_reset();
    lat = 1;
    redirect = 1'b1; redirect_pc = 64'h41;
    cycle();
    total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL brd_boot got=%b want=0", req_seen); end
    redirect = 1'b0;
    cycle();
    total++; if (req_seen !== 1'b1 || addr_seen !== 64'h40) begin bad++; $display("FAIL brd_req got=%b/%h want=1/40", req_seen, addr_seen); end
  endtask

  task automatic test_halt();
    do_reset();
    lat = 1; dec_ready = 1'b0;
    cycle();
    run(20);
    halt = 1'b1; dec_ready = 1'b1;
    req_cnt = 0;
    run(8);
    total++; if (pop_pc.size() != 4) begin bad++; $display("FAIL halt_count got=%0d want=4", pop_pc.size()); end
    for (int i = 0; i < 4 && i < pop_pc.size(); i++) begin
      total++; if (pop_pc[i] !== 64'(4*i)) begin bad++; $display("FAIL halt_pc[%0d] got=%h want=%h", i, pop_pc[i], 64'(4*i)); end
    end
    total++; if (req_cnt != 0) begin bad++; $display("FAIL halt_reqs got=%0d want=0", req_cnt); end
    total++; if (dec_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL halt_drain got=%b/%b want=0/1", dec_valid, empty); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%b want=0", imem_req); end
    halt = 1'b0;
    cycle();
    total++; if (req_seen !== 1'b1 || addr_seen !== 64'h10) begin bad++; $display("FAIL halt_resume got=%b/%h want=1/10", req_seen, addr_seen); end
    run(4);
    total++; if (pop_pc.size() < 5) begin bad++; $display("FAIL halt_post got=%0d want>=5", pop_pc.size()); end
    if (pop_pc.size() >= 5) begin
      total++; if (pop_pc[4] !== 64'h10) begin bad++; $display("FAIL halt_pc4 got=%h want=10", pop_pc[4]); end
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    halt = 1'b0; dec_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_inst = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rsp();
    test_wrap();
    test_boot_redirect();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
